serial_parallel_mult: RTL and testbench

- Sequential shift-add multiplier that computes a 2N-bit product magnitude and a sign bit from two N-bit operands, consuming one multiplier bit per clock.
- Sits directly upstream of the binary-to-BCD/view-mode stage: product[15:0] drives its 16-bit binary input, and sign drives the display minus indicator.
- Operands come from board switches; start comes from a debounced, single-pulsed push-button.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_abs_sign.sv | 34 +++
 rtl/serial_parallel_mult.sv | 129 ++++++++++++
 tb/tb_serial_parallel_mult.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and default operand width.
package mult_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_abs_sign.sv
// Operand magnitude and product-sign preparation used by the LOAD step.
// With MUL_SIGNED_EN defined the operands are two's complement; otherwise this is a pass-through.
module mult_abs_sign import mult_pkg::*; #(
    parameter int N = MULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   a_mag,
    output logic [N:0]   b_mag,
    output logic         sign
);

`ifdef MUL_SIGNED_EN
    // One extra bit so that the most negative value keeps its full magnitude.
    function automatic logic [N:0] abs_ext(input logic [N-1:0] v);
        logic [N:0] ext;
        ext = {v[N-1], v};
        if (v[N-1]) begin
            return (~ext) + {{N{1'b0}}, 1'b1};
        end else begin
            return ext;
        end
    endfunction

    assign a_mag = abs_ext(a);
    assign b_mag = abs_ext(b);
    assign sign  = a[N-1] ^ b[N-1];
`else
    assign a_mag = {1'b0, a};
    assign b_mag = {1'b0, b};
    assign sign  = 1'b0;
`endif

endmodule

// File: rtl/serial_parallel_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock, 2N-bit magnitude plus sign.
// Signed operand handling is selected with the MUL_SIGNED_EN macro (see mult_abs_sign).
module serial_parallel_mult import mult_pkg::*; #(
    parameter int N     = MULT_N,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           sign
);

    state_t           state_r;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic [N:0]       mcand_r;
    logic [2*N:0]     acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sign_pend_r;
    logic             busy_r;
    logic             done_r;
    logic [2*N-1:0]   product_r;
    logic             sign_r;

    logic [N:0]       a_mag_s;
    logic [N:0]       b_mag_s;
    logic             sign_s;
    logic [N+1:0]     sum_s;
    logic [2*N:0]     acc_next_s;

    mult_abs_sign #(.N(N)) u_abs_sign (
        .a     (a_r),
        .b     (b_r),
        .a_mag (a_mag_s),
        .b_mag (b_mag_s),
        .sign  (sign_s)
    );

    // One shift-add step: the accumulator's low half holds the unconsumed multiplier bits.
    always_comb begin
        sum_s      = {(N+2){1'b0}};
        acc_next_s = {(2*N+1){1'b0}};
        if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*N:N]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[2*N:N]};
        end
        acc_next_s = {sum_s, acc_r[N-1:1]};
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            mcand_r     <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            sign_pend_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            product_r   <= '0;
            sign_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    // |b| < 2^N, so its top bit lands as a zero in the upper half.
                    mcand_r     <= a_mag_s;
                    acc_r       <= {{N{1'b0}}, b_mag_s};
                    sign_pend_r <= sign_s;
                    cnt_r       <= '0;
                    state_r     <= RUN;
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(N - 1)) begin
                        product_r <= acc_next_s[2*N-1:0];
                        sign_r    <= sign_pend_r & (|acc_next_s[2*N-1:0]);
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r   <= RUN;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    // The DONE->IDLE edge doubles as the accept edge for a held start.
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign sign    = sign_r;

endmodule

// File: tb/tb_serial_parallel_mult.sv
// Self-checking bench for serial_parallel_mult with an arithmetic reference model.
module tb_serial_parallel_mult;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic           sign;

    int checks = 0;
    int errors = 0;
    logic [2*N:0] prev;

    serial_parallel_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .sign    (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {sign, magnitude} of the exact product.
    function automatic logic [2*N:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        longint px, py, p;
        logic   s;
`ifdef MUL_SIGNED_EN
        px = longint'($signed(x));
        py = longint'($signed(y));
`else
        px = longint'(x);
        py = longint'(y);
`endif
        p = px * py;
        s = (p < 0);
        if (s) p = -p;
        return {s, p[2*N-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input string tag);
        logic [2*N:0] exp;
        int n;
        int bc;
        exp   = ref_mul(av, bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        n  = 0;
        bc = 0;
        while (done !== 1'b1 && n < 30) begin
            if (busy === 1'b1) bc++;
            if (n == 4) check({tag, "_hold"}, {15'd0, sign, product}, {15'd0, prev});
            tick();
            n++;
        end
        if (busy === 1'b1) bc++;
        check({tag, "_lat"}, n, 9);
        check({tag, "_prod"}, {16'd0, product}, {16'd0, exp[2*N-1:0]});
        check({tag, "_sign"}, {31'd0, sign}, {31'd0, exp[2*N]});
        check({tag, "_busy"}, bc, N + 2);
        prev = exp;
        tick();
        check({tag, "_done_off"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [2*N:0] exp;
        logic [2*N:0] hold;
        logic [N-1:0] ah [0:30];
        logic [N-1:0] bh [0:30];
        int dones[$];
        int dcnt;
        int dk;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        prev  = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_prod", {16'd0, product}, 32'd0);
        check("rst_sign", {31'd0, sign}, 32'd0);
        #3 rst_n = 1'b1;
        tick();

        run_op(8'd25,  8'hFC, "p25xm4");
        run_op(8'h80,  8'h80, "m128sq");
        run_op(8'd0,   8'hFB, "zero_neg");
        run_op(8'd255, 8'd255, "max");
        run_op(8'd1,   8'd0,  "one_zero");
        for (int i = 0; i < 12; i++) begin
            run_op(N'($urandom), N'($urandom), "rand");
        end

        // Re-pulsed start mid-run, operands scrambled every cycle.
        exp   = ref_mul(8'd7, 8'd9);
        a     = 8'd7;
        b     = 8'd9;
        start = 1'b1;
        tick();
        dcnt = 0;
        dk   = 0;
        for (int k = 1; k <= 14; k++) begin
            start = (k == 3 || k == 8);
            a     = N'($urandom);
            b     = N'($urandom);
            tick();
            if (done === 1'b1) begin
                dcnt++;
                dk = k;
            end
        end
        start = 1'b0;
        check("repulse_cnt", dcnt, 1);
        check("repulse_at", dk, 9);
        check("repulse_prod", {16'd0, product}, {16'd0, exp[2*N-1:0]});
        check("repulse_idle", {31'd0, busy}, 32'd0);
        prev = exp;

        // Asynchronous reset at E5 of a run.
        a     = N'($urandom);
        b     = N'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_prod", {16'd0, product}, 32'd0);
        check("arst_sign", {31'd0, sign}, 32'd0);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done === 1'b1) dcnt++;
        end
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) dcnt++;
        end
        check("arst_nodone", dcnt, 0);
        prev = '0;
        run_op(8'd3, 8'd3, "post_rst");

        // Back-to-back with start held high; operands change every cycle.
        hold = prev;
        for (int k = 0; k <= 30; k++) begin
            ah[k] = N'($urandom);
            bh[k] = N'($urandom);
            a     = ah[k];
            b     = bh[k];
            start = (k < 30);
            tick();
            if (done === 1'b1) begin
                dones.push_back(k);
                exp  = (k >= 9) ? ref_mul(ah[k-9], bh[k-9]) : '0;
                check("b2b_prod", {15'd0, sign, product}, {15'd0, exp});
                hold = exp;
            end else begin
                check("b2b_hold", {15'd0, sign, product}, {15'd0, hold});
            end
        end
        start = 1'b0;
        check("b2b_count", dones.size(), 3);
        check("b2b_t0", (dones.size() > 0) ? dones[0] : -1, 9);
        check("b2b_t1", (dones.size() > 1) ? dones[1] : -1, 19);
        check("b2b_t2", (dones.size() > 2) ? dones[2] : -1, 29);
        check("b2b_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
